iic_write_arb: RTL and testbench



---
 rtl/iic_write_arb.sv | 182 ++++++++++++++++++
 tb/tb_iic_write_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iic_write_arb.sv
// Two-requester scheduler for the shared IIC write engine: grant, start pulse, wait for done, bus-free gap.
// Optional watchdog in WAIT_DONE is enabled by defining IIC_ARB_WDOG_EN.
module iic_write_arb #(
  parameter logic [15:0] GAP_CYC     = 16'd250,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [3:0]  i_len0,
  input  logic [3:0]  i_len1,
  input  logic [6:0]  i_addr0,
  input  logic [6:0]  i_addr1,
  input  logic [31:0] i_dat0,
  input  logic [31:0] i_dat1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done0,
  output logic        o_done1,
  output logic        o_send_en,
  output logic [3:0]  o_send_length,
  output logic [6:0]  o_dev_addr,
  output logic [31:0] o_write_dat,
  input  logic        i_iic_done,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        send_en_q, send_en_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  len_q, len_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] gap_q, gap_d;
  logic        win;

`ifdef IIC_ARB_WDOG_EN
  logic [23:0] wd_q, wd_d;
`else
  logic        unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0)     return 4'd1;
    else if (l > 4'd4) return 4'd4;
    else               return l;
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    send_en_d = 1'b0;
    timeout_d = 1'b0;
    len_d     = len_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    gap_d     = gap_q;
    win       = 1'b0;
`ifdef IIC_ARB_WDOG_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          // On a tie the requester that did not win last time goes first.
          win     = (i_req0 && i_req1) ? ~last_q : i_req1;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          len_d   = clamp_len(win ? i_len1 : i_len0);
          addr_d  = win ? i_addr1 : i_addr0;
          dat_d   = win ? i_dat1 : i_dat0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        send_en_d = 1'b1;
        state_d   = ST_WAIT;
`ifdef IIC_ARB_WDOG_EN
        wd_d      = '0;
`endif
      end
      ST_WAIT: begin
        if (i_iic_done) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          last_d  = owner_q;
          gap_d   = GAP_CYC;
          state_d = ST_GAP;
        end
`ifdef IIC_ARB_WDOG_EN
        else if (wd_q == TIMEOUT_CYC - 24'd1) begin
          done0_d   = ~owner_q;
          done1_d   = owner_q;
          timeout_d = 1'b1;
          last_d    = owner_q;
          gap_d     = GAP_CYC;
          state_d   = ST_GAP;
        end else begin
          wd_d = wd_q + 24'd1;
        end
`endif
      end
      default: begin
        // Gap spans GAP_CYC cycles (minimum one) so the next grant lands GAP_CYC+2 after done.
        if (gap_q <= 16'd1) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      send_en_q <= 1'b0;
      timeout_q <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      dat_q     <= '0;
      gap_q     <= '0;
`ifdef IIC_ARB_WDOG_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      send_en_q <= send_en_d;
      timeout_q <= timeout_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      gap_q     <= gap_d;
`ifdef IIC_ARB_WDOG_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign o_gnt0        = gnt0_q;
  assign o_gnt1        = gnt1_q;
  assign o_done0       = done0_q;
  assign o_done1       = done1_q;
  assign o_send_en     = send_en_q;
  assign o_send_length = len_q;
  assign o_dev_addr    = addr_q;
  assign o_write_dat   = dat_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_iic_write_arb.sv
// Self-checking bench for iic_write_arb: vector table for grant/clamp/latch, hand sequences for gap, reset, watchdog.
module tb_iic_write_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, iic_done;
  logic [3:0]  len0, len1;
  logic [6:0]  addr0, addr1;
  logic [31:0] dat0, dat1;
  logic        gnt0, gnt1, done0, done1, send_en, busy, tmo;
  logic [3:0]  send_len;
  logic [6:0]  dev_addr;
  logic [31:0] wdat;
  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  iic_write_arb #(.GAP_CYC(16'd250), .TIMEOUT_CYC(24'd100)) dut (
    .i_clk_50m(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_len0(len0), .i_len1(len1),
    .i_addr0(addr0), .i_addr1(addr1), .i_dat0(dat0), .i_dat1(dat1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_send_en(send_en), .o_send_length(send_len), .o_dev_addr(dev_addr),
    .o_write_dat(wdat), .i_iic_done(iic_done), .o_busy(busy), .o_timeout(tmo)
  );

  typedef struct {
    logic        r0, r1;
    logic [3:0]  l0, l1;
    logic [6:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        win;
    logic [3:0]  elen;
    logic [6:0]  eaddr;
    logic [31:0] edat;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle the done pulse is visible; ends in the first IDLE cycle.
  task automatic wait_gap();
    int seen = 0;
    for (int i = 0; i < 249; i++) begin
      tick();
      if (send_en || gnt0 || gnt1 || done0 || done1) seen++;
    end
    chk("gap_quiet", seen, 0);
    chk("gap_busy", busy, 1'b1);
    tick();
    chk("gap_idle", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_out"}, {gnt0, gnt1, done0, done1, send_en, busy, tmo}, 7'd0);
    chk({nm, "_len"}, send_len, 4'd0);
    chk({nm, "_addr"}, dev_addr, 7'd0);
    chk({nm, "_dat"}, wdat, 32'd0);
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b0, 4'd1, 4'd0, 7'h50, 7'h00, 32'hA5000000, 32'h0,        1'b0, 4'd1, 7'h50, 32'hA5000000};
    tv[1] = '{1'b1, 1'b1, 4'd0, 4'hF, 7'h11, 7'h22, 32'h11111111, 32'h22222222, 1'b1, 4'd4, 7'h22, 32'h22222222};
    tv[2] = '{1'b1, 1'b1, 4'd0, 4'd2, 7'h13, 7'h23, 32'hDEADBEEF, 32'h00000001, 1'b0, 4'd1, 7'h13, 32'hDEADBEEF};
    tv[3] = '{1'b1, 1'b1, 4'd4, 4'd3, 7'h14, 7'h24, 32'h00000002, 32'hCAFE0000, 1'b1, 4'd3, 7'h24, 32'hCAFE0000};
    tv[4] = '{1'b1, 1'b1, 4'd4, 4'd1, 7'h15, 7'h25, 32'h12345678, 32'h00000003, 1'b0, 4'd4, 7'h15, 32'h12345678};
    tv[5] = '{1'b0, 1'b1, 4'd0, 4'd2, 7'h00, 7'h26, 32'h0,        32'hAB000000, 1'b1, 4'd2, 7'h26, 32'hAB000000};
    tv[6] = '{1'b1, 1'b0, 4'd5, 4'd0, 7'h16, 7'h00, 32'h0F0F0F0F, 32'h0,        1'b0, 4'd4, 7'h16, 32'h0F0F0F0F};

    rst = 1'b1; req0 = 0; req1 = 0; iic_done = 0;
    len0 = 0; len1 = 0; addr0 = 0; addr1 = 0; dat0 = 0; dat1 = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Table: grant choice, clamp, latching, done routing, gap length.
    for (int v = 0; v < 7; v++) begin
      req0 = tv[v].r0; req1 = tv[v].r1;
      len0 = tv[v].l0; len1 = tv[v].l1;
      addr0 = tv[v].a0; addr1 = tv[v].a1;
      dat0 = tv[v].d0; dat1 = tv[v].d1;
      tick();
      chk($sformatf("v%0d_gnt0", v), gnt0, !tv[v].win);
      chk($sformatf("v%0d_gnt1", v), gnt1, tv[v].win);
      req0 = 0; req1 = 0;
      tick();
      chk($sformatf("v%0d_send_en", v), send_en, 1'b1);
      chk($sformatf("v%0d_gnt_pulse", v), {gnt0, gnt1}, 2'b00);
      chk($sformatf("v%0d_len", v), send_len, tv[v].elen);
      chk($sformatf("v%0d_addr", v), dev_addr, tv[v].eaddr);
      chk($sformatf("v%0d_dat", v), wdat, tv[v].edat);
      tick(); tick(); tick();
      chk($sformatf("v%0d_send_once", v), {send_en, done0, done1, busy}, 4'b0001);
      iic_done = 1;
      tick();
      iic_done = 0;
      chk($sformatf("v%0d_done0", v), done0, !tv[v].win);
      chk($sformatf("v%0d_done1", v), done1, tv[v].win);
      chk($sformatf("v%0d_tmo", v), tmo, 1'b0);
      wait_gap();
      chk($sformatf("v%0d_hold_addr", v), dev_addr, tv[v].eaddr);
    end

    // Stray done in IDLE is ignored.
    iic_done = 1;
    tick();
    iic_done = 0;
    chk("stray_done", {done0, done1, busy}, 3'b000);
    tick();
    chk("stray_idle", {done0, done1, busy}, 3'b000);

    // req1 raised during WAIT_DONE is granted exactly GAP_CYC+2 after done.
    req0 = 1; addr0 = 7'h33; len0 = 4'd2; dat0 = 32'h33000000;
    tick();
    chk("late_gnt0", gnt0, 1'b1);
    req0 = 0;
    tick();
    chk("late_send0", send_en, 1'b1);
    tick();
    req1 = 1; addr1 = 7'h44; len1 = 4'd2; dat1 = 32'h44440000;
    tick(); tick();
    iic_done = 1;
    tick();
    iic_done = 0;
    chk("late_done0", done0, 1'b1);
    chk("late_no_gnt1", gnt1, 1'b0);
    begin
      int early = 0;
      for (int i = 0; i < 250; i++) begin
        tick();
        if (gnt1 || send_en) early++;
      end
      chk("late_gnt1_early", early, 0);
    end
    tick();
    chk("late_gnt1", gnt1, 1'b1);
    req1 = 0;
    tick();
    chk("late_send1", send_en, 1'b1);
    chk("late_addr1", dev_addr, 7'h44);
    iic_done = 1;
    tick();
    iic_done = 0;
    chk("late_done1", done1, 1'b1);
    wait_gap();

    // Reset in WAIT_DONE, then the tie sequence restarts with req0.
    req0 = 1; addr0 = 7'h5A; len0 = 4'd3; dat0 = 32'h5A5A5A5A;
    tick();
    req0 = 0;
    tick(); tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req0 = 1; req1 = 1;
      addr0 = 7'h60; addr1 = 7'h61;
      tick();
      chk($sformatf("fair%0d_gnt0", k), gnt0, (k % 2) == 0);
      chk($sformatf("fair%0d_gnt1", k), gnt1, (k % 2) == 1);
      req0 = 0; req1 = 0;
      tick();
      chk($sformatf("fair%0d_addr", k), dev_addr, (k % 2) ? 7'h61 : 7'h60);
      tick();
      iic_done = 1;
      tick();
      iic_done = 0;
      chk($sformatf("fair%0d_done", k), {done0, done1}, (k % 2) ? 2'b01 : 2'b10);
      wait_gap();
    end

    // Engine never answers.
    req0 = 1; addr0 = 7'h70;
    tick();
    req0 = 0;
    tick();
    chk("wd_send", send_en, 1'b1);
`ifdef IIC_ARB_WDOG_EN
    for (int i = 0; i < 99; i++) tick();
    chk("wd_pre", {tmo, done0}, 2'b00);
    tick();
    chk("wd_tmo", tmo, 1'b1);
    chk("wd_done0", done0, 1'b1);
    wait_gap();
`else
    begin
      int seen = 0;
      for (int i = 0; i < 10000; i++) begin
        tick();
        if (done0 || done1 || tmo) seen++;
      end
      chk("nowd_quiet", seen, 0);
    end
    chk("nowd_busy", busy, 1'b1);
    iic_done = 1;
    tick();
    iic_done = 0;
    chk("nowd_done0", done0, 1'b1);
    chk("nowd_tmo", tmo, 1'b0);
    wait_gap();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
